// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg : shared FSM state type and lane-packing helper for the feeder.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic int lane_offset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
// ---------------------------------------------------------------------------
// skew_delay_line : DEPTH-stage registered shift chain, async active-low reset.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) stages[k] <= '0;
    end else begin
      stages[0] <= din;
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder : re-times operand vectors into a diagonal wavefront
// for one edge of the systolic MAC array. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 9,
  parameter int K_MAX      = 16,
  parameter int CNT_W      = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        k_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N*DATA_WIDTH-1:0] in_data_i,
  output logic [N*DATA_WIDTH-1:0] lane_data_o,
  output logic [N-1:0]            lane_en_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int FLUSH_W = (N > 1) ? $clog2(N) : 1;

  feeder_state_t      state;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   count;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [CNT_W-1:0]   clamped_len;
  logic               accept;

  assign clamped_len = (k_len_i > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len_i;
  assign accept      = in_valid_i & in_ready_o;

  // FLUSH holds for N cycles so the last element clears lane N-1 before DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      len        <= '0;
      count      <= '0;
      flush_cnt  <= '0;
      in_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            len    <= clamped_len;
            count  <= '0;
            busy_o <= 1'b1;
            if (clamped_len == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= LOAD;
              in_ready_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (count + CNT_W'(1) == len) begin
              state      <= FLUSH;
              in_ready_o <= 1'b0;
              flush_cnt  <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(N - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int OFF = lane_offset(i, DATA_WIDTH);
    logic [DATA_WIDTH:0] stage_in;
    logic [DATA_WIDTH:0] stage_out;

    // Non-accept edges inject {0,0} so downstream accumulators hold.
    assign stage_in = accept ? {1'b1, in_data_i[OFF +: DATA_WIDTH]} : '0;

    skew_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (DATA_WIDTH + 1)
    ) u_delay (
      .clk  (clk),
      .rstn (rstn),
      .din  (stage_in),
      .dout (stage_out)
    );

    assign lane_en_o[i]                   = stage_out[DATA_WIDTH];
    assign lane_data_o[OFF +: DATA_WIDTH] = stage_out[DATA_WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder : directed self-checking bench for the skew feeder.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int KM = 16;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start_i;
  logic [CW-1:0]   k_len_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [N*DW-1:0] in_data_i;
  logic [N*DW-1:0] lane_data_o;
  logic [N-1:0]    lane_en_o;
  logic            busy_o;
  logic            done_o;

  int n_checks = 0;
  int n_errors = 0;

  int              acc_edge [32];
  logic [N*DW-1:0] vdata    [32];

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .K_MAX(KM), .CNT_W(CW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .k_len_i     (k_len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .lane_data_o (lane_data_o),
    .lane_en_o   (lane_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job, then step cycle by cycle: vectors are offered on the edges in
  // acc_edge[0..n_valid-1]; the first n_acc of them are expected to be taken.
  // Edge 0 is the start edge; t counts cycles after edge t.
  task automatic run_job(input string name, input int klen, input int n_valid,
                         input int n_acc, input int ign_a, input int ign_b);
    int last;
    int done_t;
    logic [N*DW-1:0] exp_data;
    logic [N-1:0]    exp_en;
    last   = (n_acc > 0) ? acc_edge[n_acc-1] : 0;
    done_t = (n_acc > 0) ? last + N : 0;
    start_i    = 1'b1;
    k_len_i    = klen[CW-1:0];
    in_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int t = 0; t <= done_t + 2; t++) begin
      exp_data = '0;
      exp_en   = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < n_acc; j++)
          if (acc_edge[j] + i == t) begin
            exp_en[i]              = 1'b1;
            exp_data[i*DW +: DW]   = vdata[j][i*DW +: DW];
          end
      check($sformatf("%s data t=%0d", name, t), 64'(lane_data_o), 64'(exp_data));
      check($sformatf("%s en t=%0d", name, t), 64'(lane_en_o), 64'(exp_en));
      check($sformatf("%s done t=%0d", name, t), 64'(done_o), 64'(t == done_t));
      check($sformatf("%s busy t=%0d", name, t), 64'(busy_o), 64'(t <= done_t));
      check($sformatf("%s ready t=%0d", name, t), 64'(in_ready_o), 64'(n_acc > 0 && t < last));
      in_valid_i = 1'b0;
      in_data_i  = 36'h5A5A5A5A5;
      for (int j = 0; j < n_valid; j++)
        if (acc_edge[j] == t + 1) begin
          in_valid_i = 1'b1;
          in_data_i  = vdata[j];
        end
      start_i = (t == ign_a) || (t == ign_b);
      k_len_i = 5'd3;
      tick();
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    start_i    = 1'b0;
    k_len_i    = '0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    for (int j = 0; j < 32; j++) vdata[j] = {9'(4*j+4), 9'(4*j+3), 9'(4*j+2), 9'(4*j+1)};
    tick();
    tick();
    check("reset data", 64'(lane_data_o), 64'h0);
    check("reset en", 64'(lane_en_o), 64'h0);
    check("reset ready", 64'(in_ready_o), 64'h0);
    check("reset busy", 64'(busy_o), 64'h0);
    check("reset done", 64'(done_o), 64'h0);
    rstn = 1'b1;
    tick();

    // Basic skew: {1,2,3,4} then {5,6,7,8} back-to-back.
    acc_edge[0] = 1; acc_edge[1] = 2;
    run_job("basic", 2, 2, 2, -1, -1);
    tick();

    // Two bubble cycles between the vectors.
    acc_edge[0] = 1; acc_edge[1] = 4;
    run_job("bubble", 2, 2, 2, -1, -1);
    tick();

    // k_len=20 clamps to 16; four extra offered vectors must be refused.
    for (int j = 0; j < 20; j++) acc_edge[j] = j + 1;
    run_job("clamp", 20, 20, 16, -1, -1);
    tick();

    run_job("zero", 0, 0, 0, -1, -1);
    tick();

    // Signed pass-through: lanes {-256, 255, -1, 0}.
    vdata[0] = {9'h000, 9'h1FF, 9'h0FF, 9'h100};
    acc_edge[0] = 1;
    run_job("signed", 1, 1, 1, -1, -1);
    vdata[0] = {9'd4, 9'd3, 9'd2, 9'd1};
    tick();

    // Start pulses inside LOAD (t=2) and FLUSH (t=6) must be ignored.
    for (int j = 0; j < 4; j++) acc_edge[j] = j + 1;
    run_job("ignstart", 4, 4, 4, 2, 6);
    tick();

    // Reset mid-job after 3 of 8 accepts.
    start_i = 1'b1;
    k_len_i = 5'd8;
    tick();
    start_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid_i = 1'b1;
      in_data_i  = vdata[j];
      tick();
    end
    check("midjob en before rst", 64'(lane_en_o), 64'h7);
    #2;
    rstn = 1'b0;
    #1;
    check("async rst data", 64'(lane_data_o), 64'h0);
    check("async rst en", 64'(lane_en_o), 64'h0);
    check("async rst ready", 64'(in_ready_o), 64'h0);
    check("async rst busy", 64'(busy_o), 64'h0);
    tick();
    rstn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("post rst busy t=%0d", t), 64'(busy_o), 64'h0);
      check($sformatf("post rst done t=%0d", t), 64'(done_o), 64'h0);
      check($sformatf("post rst en t=%0d", t), 64'(lane_en_o), 64'h0);
      tick();
    end
    in_valid_i = 1'b0;

    acc_edge[0] = 1; acc_edge[1] = 2;
    run_job("after rst", 2, 2, 2, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
